// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_pkg
//  Description : Shared RV32I decode constants: base opcodes, ALU operation
//                encodings and the ALU operand-1 select encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    typedef logic [6:0] opcode_t;
    typedef logic [3:0] alu_op_t;

    // Base opcodes (inst[6:0])
    localparam opcode_t OPC_OP     = 7'b0110011;
    localparam opcode_t OPC_OP_IMM = 7'b0010011;
    localparam opcode_t OPC_LOAD   = 7'b0000011;
    localparam opcode_t OPC_STORE  = 7'b0100011;
    localparam opcode_t OPC_BRANCH = 7'b1100011;
    localparam opcode_t OPC_JAL    = 7'b1101111;
    localparam opcode_t OPC_JALR   = 7'b1100111;
    localparam opcode_t OPC_LUI    = 7'b0110111;
    localparam opcode_t OPC_AUIPC  = 7'b0010111;

    // ALU operations, encoded as {inst[30], funct3}
    localparam alu_op_t ALU_ADD  = 4'b0000;
    localparam alu_op_t ALU_SUB  = 4'b1000;
    localparam alu_op_t ALU_SLL  = 4'b0001;
    localparam alu_op_t ALU_SLT  = 4'b0010;
    localparam alu_op_t ALU_SLTU = 4'b0011;
    localparam alu_op_t ALU_XOR  = 4'b0100;
    localparam alu_op_t ALU_SRL  = 4'b0101;
    localparam alu_op_t ALU_SRA  = 4'b1101;
    localparam alu_op_t ALU_OR   = 4'b0110;
    localparam alu_op_t ALU_AND  = 4'b0111;

    // ALU operand-1 source
    localparam logic OP1_RS1 = 1'b0;
    localparam logic OP1_PC  = 1'b1;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/imm_gen.sv
`default_nettype none
// ============================================================================
//  Module      : imm_gen
//  Description : Combinational RV32I immediate generator. Selects the
//                immediate format from the opcode and sign-extends from
//                inst[31]; OP-IMM shifts yield the zero-extended shamt.
//                Opcodes without an immediate (OP, unsupported) give 0.
//  Ports       : inst [31:0] in  - instruction word
//                imm  [31:0] out - decoded immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic       w_sign;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];
    assign w_sign   = inst[31];

    always_comb begin
        imm = 32'h0000_0000;
        case (w_opcode)
            OPC_OP_IMM: begin
                // SLLI/SRLI/SRAI: inst[30] selects SRA, so it must not leak
                // into the immediate; only the shift amount is meaningful.
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101)
                    imm = {27'h0, inst[24:20]};
                else
                    imm = {{20{w_sign}}, inst[31:20]};
            end
            OPC_LOAD,
            OPC_JALR:   imm = {{20{w_sign}}, inst[31:20]};
            OPC_STORE:  imm = {{20{w_sign}}, inst[31:25], inst[11:7]};
            OPC_BRANCH: imm = {{19{w_sign}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            OPC_LUI,
            OPC_AUIPC:  imm = {inst[31:12], 12'h000};
            OPC_JAL:    imm = {{11{w_sign}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default:    imm = 32'h0000_0000;
        endcase
    end

endmodule : imm_gen
`default_nettype wire

// File: rtl/decoder.sv
`default_nettype none
// ============================================================================
//  Module      : decoder
//  Description : Registered RV32I instruction decoder. Decodes register
//                indices, ALU operation, write enable, immediate and
//                operand-1 select with one cycle of latency. Unsupported
//                opcodes raise illegal with every other output at zero.
//  Ports       : clk            in       - clock, rising edge
//                rst_n          in       - asynchronous active-low reset
//                inst     [31:0] in      - instruction word
//                rs1/rs2/rd [4:0] out    - register indices
//                alu_ctrl [3:0] out      - ALU operation
//                w_en           out      - register-file write enable
//                imm      [31:0] out     - immediate
//                op1_sel        out      - 0 = rs1, 1 = PC
//                illegal        out      - unsupported opcode
//  Revision    : 1.0 - initial release
// ============================================================================
module decoder
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] inst,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [3:0]  alu_ctrl,
    output logic        w_en,
    output logic [31:0] imm,
    output logic        op1_sel,
    output logic        illegal
);

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_raw;

    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [3:0]  w_alu_ctrl;
    logic        w_writes;
    logic        w_w_en;
    logic [31:0] w_imm;
    logic        w_op1_sel;
    logic        w_illegal;

    assign w_opcode = inst[6:0];
    assign w_funct3 = inst[14:12];

    imm_gen u_imm_gen (
        .inst (inst),
        .imm  (w_imm_raw)
    );

    always_comb begin
        w_rs1      = 5'd0;
        w_rs2      = 5'd0;
        w_rd       = 5'd0;
        w_alu_ctrl = ALU_ADD;
        w_writes   = 1'b0;
        w_op1_sel  = OP1_RS1;
        w_illegal  = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_rs1      = inst[19:15];
                w_rs2      = inst[24:20];
                w_rd       = inst[11:7];
                w_alu_ctrl = {inst[30], w_funct3};
                w_writes   = 1'b1;
            end
            OPC_OP_IMM: begin
                // inst[30] is only an opcode bit for SRAI; elsewhere it is
                // part of the immediate.
                w_rs1      = inst[19:15];
                w_rd       = inst[11:7];
                w_alu_ctrl = {(w_funct3 == 3'b101) ? inst[30] : 1'b0, w_funct3};
                w_writes   = 1'b1;
            end
            OPC_LOAD,
            OPC_JALR: begin
                w_rs1    = inst[19:15];
                w_rd     = inst[11:7];
                w_writes = 1'b1;
            end
            OPC_STORE: begin
                w_rs1 = inst[19:15];
                w_rs2 = inst[24:20];
            end
            OPC_BRANCH: begin
                w_rs1      = inst[19:15];
                w_rs2      = inst[24:20];
                w_alu_ctrl = ALU_SUB;
                w_op1_sel  = OP1_PC;
            end
            OPC_JAL,
            OPC_AUIPC: begin
                w_rd      = inst[11:7];
                w_writes  = 1'b1;
                w_op1_sel = OP1_PC;
            end
            OPC_LUI: begin
                w_rd     = inst[11:7];
                w_writes = 1'b1;
            end
            default: w_illegal = 1'b1;
        endcase
        // Writes to x0 are discarded, so never enable them.
        w_w_en = w_writes && (w_rd != 5'd0);
        w_imm  = w_illegal ? 32'h0000_0000 : w_imm_raw;
    end

    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [3:0]  r_alu_ctrl;
    logic        r_w_en;
    logic [31:0] r_imm;
    logic        r_op1_sel;
    logic        r_illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs1      <= 5'd0;
            r_rs2      <= 5'd0;
            r_rd       <= 5'd0;
            r_alu_ctrl <= 4'd0;
            r_w_en     <= 1'b0;
            r_imm      <= 32'h0000_0000;
            r_op1_sel  <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            r_alu_ctrl <= w_alu_ctrl;
            r_w_en     <= w_w_en;
            r_imm      <= w_imm;
            r_op1_sel  <= w_op1_sel;
            r_illegal  <= w_illegal;
        end
    end

    assign rs1      = r_rs1;
    assign rs2      = r_rs2;
    assign rd       = r_rd;
    assign alu_ctrl = r_alu_ctrl;
    assign w_en     = r_w_en;
    assign imm      = r_imm;
    assign op1_sel  = r_op1_sel;
    assign illegal  = r_illegal;

endmodule : decoder
`default_nettype wire

// File: tb/tb_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decoder
//  Description : Self-checking bench for decoder: directed vectors, an
//                asynchronous reset probe and randomized instructions checked
//                against a behavioural RV32I decode model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder;

    logic        clk;
    logic        rst_n;
    logic [31:0] inst;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_ctrl;
    logic        w_en;
    logic [31:0] imm;
    logic        op1_sel;
    logic        illegal;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic [3:0]  alu;
        logic        wen;
        logic [31:0] imm;
        logic        op1;
        logic        ill;
    } dec_t;

    decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .inst     (inst),
        .rs1      (rs1),
        .rs2      (rs2),
        .rd       (rd),
        .alu_ctrl (alu_ctrl),
        .w_en     (w_en),
        .imm      (imm),
        .op1_sel  (op1_sel),
        .illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Sign-extend the low (n) bits of v.
    function automatic logic [31:0] sx(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << n;
        return (v >> (n - 1)) & 32'h1 ? (v | m) : (v & ~m);
    endfunction

    // Behavioural model: classify the instruction, then apply its format.
    function automatic dec_t model(input logic [31:0] x);
        dec_t e;
        int op, f3, r1, r2, d;
        logic is_op, is_imm, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_aui, writes;
        op = int'(x % 128);
        d  = int'((x >> 7) % 32);
        f3 = int'((x >> 12) % 8);
        r1 = int'((x >> 15) % 32);
        r2 = int'((x >> 20) % 32);
        is_op = (op == 'h33); is_imm = (op == 'h13); is_ld = (op == 'h03);
        is_st = (op == 'h23); is_br = (op == 'h63); is_jal = (op == 'h6F);
        is_jalr = (op == 'h67); is_lui = (op == 'h37); is_aui = (op == 'h17);
        e = '{default: '0};
        if (!(is_op || is_imm || is_ld || is_st || is_br || is_jal || is_jalr || is_lui || is_aui)) begin
            e.ill = 1'b1;
            return e;
        end
        writes = !(is_st || is_br);
        if (is_op || is_imm || is_ld || is_st || is_br || is_jalr) e.rs1 = 5'(r1);
        if (is_op || is_st || is_br) e.rs2 = 5'(r2);
        if (writes) e.rd = 5'(d);
        e.wen = writes && d != 0;
        e.op1 = is_aui || is_jal || is_br;
        if (is_br) e.alu = 4'd8;
        else if (is_op || (is_imm && f3 == 5)) e.alu = 4'(f3 + 8 * int'(x[30]));
        else if (is_imm) e.alu = 4'(f3);
        if (is_imm && (f3 == 1 || f3 == 5)) e.imm = 32'(r2);
        else if (is_imm || is_ld || is_jalr) e.imm = sx(x >> 20, 12);
        else if (is_st) e.imm = sx(((x >> 25) << 5) + 32'(d), 12);
        else if (is_br)
            e.imm = sx((((x >> 31) & 1) << 12) + (((x >> 7) & 1) << 11) +
                       (((x >> 25) & 63) << 5) + (((x >> 8) & 15) << 1), 13);
        else if (is_lui || is_aui) e.imm = (x >> 12) << 12;
        else if (is_jal)
            e.imm = sx((((x >> 31) & 1) << 20) + (((x >> 12) & 255) << 12) +
                       (((x >> 20) & 1) << 11) + (((x >> 21) & 1023) << 1), 21);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_all(input string tag, input dec_t e);
        chk({tag, ".rs1"},     32'(rs1),      32'(e.rs1));
        chk({tag, ".rs2"},     32'(rs2),      32'(e.rs2));
        chk({tag, ".rd"},      32'(rd),       32'(e.rd));
        chk({tag, ".alu"},     32'(alu_ctrl), 32'(e.alu));
        chk({tag, ".w_en"},    32'(w_en),     32'(e.wen));
        chk({tag, ".imm"},     imm,           e.imm);
        chk({tag, ".op1_sel"}, 32'(op1_sel),  32'(e.op1));
        chk({tag, ".illegal"}, 32'(illegal),  32'(e.ill));
    endtask

    // Apply x, clock it in, and check one cycle later against the model.
    task automatic step(input string tag, input logic [31:0] x);
        inst = x;
        @(posedge clk);
        #1;
        chk_all(tag, model(x));
    endtask

    localparam logic [6:0] OPCS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                                        7'h6F, 7'h67, 7'h37, 7'h17};

    dec_t zero;
    logic [31:0] r;

    initial begin
        zero  = '{default: '0};
        rst_n = 1'b0;
        inst  = 32'h0020_81B3;
        // An instruction presented during reset must not come through.
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", zero);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_all("post_reset_no_edge", zero);
        @(posedge clk);
        #1;
        chk_all("first_edge", model(32'h0020_81B3));

        // Directed vectors with hand-derived expectations.
        inst = 32'h0020_81B3; @(posedge clk); #1;
        chk_all("add", '{rs1:5'd1, rs2:5'd2, rd:5'd3, alu:4'b0000, wen:1'b1,
                         imm:32'h0, op1:1'b0, ill:1'b0});
        inst = 32'hFFF0_0293; @(posedge clk); #1;
        chk_all("addi", '{rs1:5'd0, rs2:5'd0, rd:5'd5, alu:4'b0000, wen:1'b1,
                          imm:32'hFFFF_FFFF, op1:1'b0, ill:1'b0});
        inst = 32'h0020_A423; @(posedge clk); #1;
        chk_all("sw", '{rs1:5'd1, rs2:5'd2, rd:5'd0, alu:4'b0000, wen:1'b0,
                        imm:32'h8, op1:1'b0, ill:1'b0});
        inst = 32'h1234_5097; @(posedge clk); #1;
        chk_all("auipc", '{rs1:5'd0, rs2:5'd0, rd:5'd1, alu:4'b0000, wen:1'b1,
                           imm:32'h1234_5000, op1:1'b1, ill:1'b0});
        inst = 32'h4033_D313; @(posedge clk); #1;
        chk_all("srai", '{rs1:5'd7, rs2:5'd0, rd:5'd6, alu:4'b1101, wen:1'b1,
                          imm:32'h3, op1:1'b0, ill:1'b0});
        inst = 32'hFFFF_FFFF; @(posedge clk); #1;
        chk_all("illegal", '{rs1:5'd0, rs2:5'd0, rd:5'd0, alu:4'b0000, wen:1'b0,
                             imm:32'h0, op1:1'b0, ill:1'b1});
        // Write to x0 must not enable the register file.
        step("addi_x0", 32'h0010_0013);
        step("beq",     32'hFE20_8EE3);
        step("jal",     32'hFFDF_F0EF);
        step("sub",     32'h4020_81B3);

        // Asynchronous reset mid-period while outputs are nonzero.
        inst = 32'h1234_5097; @(posedge clk); #1;
        chk("pre_async.imm", imm, 32'h1234_5000);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", zero);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk_all("resume", model(32'h1234_5097));

        // Randomized instructions, mostly legal opcodes.
        for (int i = 0; i < 300; i++) begin
            r = $urandom();
            if ($urandom_range(0, 9) == 0) step("rand_any", r);
            else step("rand", {r[31:7], OPCS[$urandom_range(0, 8)]});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_decoder
`default_nettype wire
